i2s_rx: RTL

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_if.sv | 22 ++
 rtl/i2s_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/i2s_rx_if.sv
// I2S receiver pin and sample bundle: serial pins in, parallel frame out.
interface i2s_rx_if #(
  parameter int DATA_W = 24
);
  logic                     i_bck;
  logic                     i_ws;
  logic                     i_sdi;
  logic signed [DATA_W-1:0] o_left;
  logic signed [DATA_W-1:0] o_right;
  logic                     o_valid;
  logic                     o_frame_err;

  modport master (
    output i_bck, i_ws, i_sdi,
    input  o_left, o_right, o_valid, o_frame_err
  );

  modport slave (
    input  i_bck, i_ws, i_sdi,
    output o_left, o_right, o_valid, o_frame_err
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCK/WS/SDI on the system clock and
// publishes coherent left/right sample pairs after slot-length checking.
module i2s_rx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic    i_clk_sys,
  input  logic    i_rstn,
  i2s_rx_if.slave bus
);

  typedef enum logic [0:0] {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [5:0] CNT_LAST = 6'(SLOT_W - 1);
  localparam logic [5:0] CNT_DATA = 6'(DATA_W);
  localparam logic [5:0] CNT_MAX  = 6'd63;

  state_t              state;
  state_t              state_nxt;
  logic                bck_m, bck_s, bck_d;
  logic                ws_m, ws_s;
  logic                sdi_m, sdi_s;
  logic                ws_prev;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   left_hold;
  logic                left_ok;
  logic [DATA_W-1:0]   left_q;
  logic [DATA_W-1:0]   right_q;
  logic                valid_q;
  logic                err_q;
  logic                rise;
  logic                chg;
  logic                slot_full;
  logic                latch_left;
  logic                publish;
  logic                slot_err;

  // Synchronisers for the asynchronous I2S pins; BCK has a third stage for edge detect.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rstn) begin
      bck_m <= 1'b0;
      bck_s <= 1'b0;
      bck_d <= 1'b0;
      ws_m  <= 1'b0;
      ws_s  <= 1'b0;
      sdi_m <= 1'b0;
      sdi_s <= 1'b0;
    end else begin
      bck_m <= bus.i_bck;
      bck_s <= bck_m;
      bck_d <= bck_s;
      ws_m  <= bus.i_ws;
      ws_s  <= ws_m;
      sdi_m <= bus.i_sdi;
      sdi_s <= sdi_m;
    end
  end

  assign rise      = bck_s & ~bck_d;
  assign chg       = rise & (ws_s != ws_prev);
  assign slot_full = (cnt == CNT_LAST);

  // FSM state register.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rstn) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: lock onto the first left-slot start, then run freely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SYNC: begin
        if (chg && !ws_s) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_SYNC;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_SYNC;
    endcase
  end

  // FSM outputs: decode what a WS change means for the slot just finished.
  always_comb begin
    latch_left = 1'b0;
    publish    = 1'b0;
    slot_err   = 1'b0;
    case (state)
      ST_RUN: begin
        if (chg && slot_full) begin
          latch_left = ~ws_prev;
          publish    = ws_prev & left_ok;
        end else if (chg) begin
          slot_err   = 1'b1;
        end else begin
          latch_left = 1'b0;
        end
      end
      default: begin
        latch_left = 1'b0;
      end
    endcase
  end

  // Slot datapath: bit counter, shift register, left holding and frame publish.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rstn) begin
      ws_prev   <= 1'b0;
      cnt       <= 6'd0;
      shreg     <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= publish;
      err_q   <= slot_err;
      if (rise) begin
        ws_prev <= ws_s;
        if (chg) begin
          cnt <= 6'd0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 6'd1;
        end
      end
      // The old shreg is consumed by the latch/publish below in this same cycle.
      if (chg) begin
        shreg <= '0;
      end else if (rise && (cnt < CNT_DATA)) begin
        shreg <= {shreg[DATA_W-2:0], sdi_s};
      end
      if (latch_left) begin
        left_hold <= shreg;
        left_ok   <= 1'b1;
      end else if (publish || slot_err) begin
        left_ok   <= 1'b0;
      end
      if (publish) begin
        left_q  <= left_hold;
        right_q <= shreg;
      end
    end
  end

  assign bus.o_left      = left_q;
  assign bus.o_right     = right_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = err_q;

endmodule
